// File: rtl/m_stage_reg_if.sv
// EX->MEM stage bundle: control levels from the hazard unit, E-stage payload in,
// registered M-stage contents out.
interface m_stage_reg_if #(
    parameter int W     = 32,
    parameter int EXC_W = 5,
    parameter int CNT_W = 4
);
    logic             en;
    logic             flush;
    logic             req;

    logic [W-1:0]     E_instr;
    logic [4:0]       E_A2;
    logic [4:0]       E_A3;
    logic [W-1:0]     E_AR;
    logic [W-1:0]     E_V2;
    logic [W-1:0]     E_pc;
    logic             E_bd;
    logic [EXC_W-1:0] E_exc;
    logic             E_ov;

    logic [W-1:0]     M_instr;
    logic [4:0]       M_A2;
    logic [4:0]       M_A3;
    logic [W-1:0]     M_AR;
    logic [W-1:0]     M_V2;
    logic [W-1:0]     M_pc;
    logic [W-1:0]     M_pc8;
    logic             M_bd;
    logic [EXC_W-1:0] M_exc;
    logic             M_valid;
    logic [CNT_W-1:0] M_hold_cnt;

    // Driver side: hazard unit plus E stage.
    modport master (
        output en, flush, req,
        output E_instr, E_A2, E_A3, E_AR, E_V2, E_pc, E_bd, E_exc, E_ov,
        input  M_instr, M_A2, M_A3, M_AR, M_V2, M_pc, M_pc8, M_bd, M_exc,
        input  M_valid, M_hold_cnt
    );

    // Pipeline register side.
    modport slave (
        input  en, flush, req,
        input  E_instr, E_A2, E_A3, E_AR, E_V2, E_pc, E_bd, E_exc, E_ov,
        output M_instr, M_A2, M_A3, M_AR, M_V2, M_pc, M_pc8, M_bd, M_exc,
        output M_valid, M_hold_cnt
    );
endinterface

// File: rtl/m_stage_reg.sv
// EX->MEM pipeline register with prioritised reset / exception clear / bubble /
// stall-hold / load actions, overflow merge into the exception code and
// writeback suppression for excepting instructions.
module m_stage_reg #(
    parameter int               W          = 32,
    parameter logic [W-1:0]     RESET_PC   = 32'h0000_3000,
    parameter logic [W-1:0]     HANDLER_PC = 32'h0000_4180,
    parameter int               EXC_W      = 5,
    parameter logic [EXC_W-1:0] OV_CODE    = 5'd12,
    parameter int               CNT_W      = 4
) (
    input logic         clk,
    input logic         reset,
    m_stage_reg_if.slave bus
);
    localparam logic [W-1:0]     RESET_PC8   = RESET_PC + W'(8);
    localparam logic [W-1:0]     HANDLER_PC8 = HANDLER_PC + W'(8);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [W-1:0]     instr_q;
    logic [4:0]       a2_q;
    logic [4:0]       a3_q;
    logic [W-1:0]     ar_q;
    logic [W-1:0]     v2_q;
    logic [W-1:0]     pc_q;
    logic [W-1:0]     pc8_q;
    logic             bd_q;
    logic [EXC_W-1:0] exc_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [EXC_W-1:0] exc_merged;
    logic [4:0]       a3_load;
    logic [W-1:0]     e_pc8;

    // Earlier-stage exception outranks a fresh overflow; excepting instructions never write back.
    always_comb begin
        exc_merged = '0;
        if (bus.E_exc != '0)
            exc_merged = bus.E_exc;
        else if (bus.E_ov)
            exc_merged = OV_CODE;
        a3_load = (exc_merged != '0) ? 5'd0 : bus.E_A3;
        e_pc8   = bus.E_pc + W'(8);
    end

    // One action per edge: reset > req > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset || bus.req) begin
            instr_q <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            ar_q    <= '0;
            v2_q    <= '0;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            pc_q    <= reset ? RESET_PC  : HANDLER_PC;
            pc8_q   <= reset ? RESET_PC8 : HANDLER_PC8;
        end else if (bus.flush) begin
            // Bubble keeps the slot's PC/BD so a later exception can still report EPC.
            instr_q <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            ar_q    <= '0;
            v2_q    <= '0;
            exc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            pc_q    <= bus.E_pc;
            pc8_q   <= e_pc8;
            bd_q    <= bus.E_bd;
        end else if (!bus.en) begin
            if (!valid_q)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            instr_q <= bus.E_instr;
            a2_q    <= bus.E_A2;
            a3_q    <= a3_load;
            ar_q    <= bus.E_AR;
            v2_q    <= bus.E_V2;
            pc_q    <= bus.E_pc;
            pc8_q   <= e_pc8;
            bd_q    <= bus.E_bd;
            exc_q   <= exc_merged;
            valid_q <= 1'b1;
            cnt_q   <= '0;
        end
    end

    assign bus.M_instr    = instr_q;
    assign bus.M_A2       = a2_q;
    assign bus.M_A3       = a3_q;
    assign bus.M_AR       = ar_q;
    assign bus.M_V2       = v2_q;
    assign bus.M_pc       = pc_q;
    assign bus.M_pc8      = pc8_q;
    assign bus.M_bd       = bd_q;
    assign bus.M_exc      = exc_q;
    assign bus.M_valid    = valid_q;
    assign bus.M_hold_cnt = cnt_q;
endmodule

// File: tb/tb_m_stage_reg.sv
// Self-checking bench for m_stage_reg: directed scenarios plus a randomized run
// against a field-level reference model of the stage contents.
module tb_m_stage_reg;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    m_stage_reg_if #(.W(32), .EXC_W(5), .CNT_W(4)) bus ();

    m_stage_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model of the stage contents.
    logic [31:0] x_instr, x_ar, x_v2, x_pc, x_pc8;
    logic [4:0]  x_a2, x_a3, x_exc;
    logic        x_bd, x_valid;
    int          x_cnt;

    function automatic logic [212:0] dut_state();
        return {bus.M_instr, bus.M_A2, bus.M_A3, bus.M_AR, bus.M_V2, bus.M_pc,
                bus.M_pc8, bus.M_bd, bus.M_exc, bus.M_valid, bus.M_hold_cnt};
    endfunction

    function automatic logic [212:0] model_state();
        logic [3:0] c;
        c = 4'(x_cnt);
        return {x_instr, x_a2, x_a3, x_ar, x_v2, x_pc, x_pc8, x_bd, x_exc, x_valid, c};
    endfunction

    task automatic clear_slot(input logic [31:0] pc, input logic bd);
        x_instr = 0; x_a2 = 0; x_a3 = 0; x_ar = 0; x_v2 = 0; x_exc = 0;
        x_valid = 0; x_cnt = 0;
        x_pc = pc; x_pc8 = pc + 32'd8; x_bd = bd;
    endtask

    // Apply the current inputs to the model, then let the DUT take the edge.
    task automatic step();
        if (reset)
            clear_slot(32'h3000, 1'b0);
        else if (bus.req)
            clear_slot(32'h4180, 1'b0);
        else if (bus.flush)
            clear_slot(bus.E_pc, bus.E_bd);
        else if (!bus.en) begin
            if (x_valid && x_cnt < 15) x_cnt++;
        end else begin
            x_exc   = (bus.E_exc != 0) ? bus.E_exc : (bus.E_ov ? 5'd12 : 5'd0);
            x_a3    = (x_exc != 0) ? 5'd0 : bus.E_A3;
            x_instr = bus.E_instr; x_a2 = bus.E_A2; x_ar = bus.E_AR; x_v2 = bus.E_V2;
            x_pc    = bus.E_pc; x_pc8 = bus.E_pc + 32'd8; x_bd = bus.E_bd;
            x_valid = 1; x_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; bus.en = 1; bus.flush = 0; bus.req = 0;
        bus.E_instr = 0; bus.E_A2 = 0; bus.E_A3 = 0; bus.E_AR = 0; bus.E_V2 = 0;
        bus.E_pc = 0; bus.E_bd = 0; bus.E_exc = 0; bus.E_ov = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        step();
        step();
        n_tests++;
        if (bus.M_pc !== 32'h3000 || bus.M_pc8 !== 32'h3008) begin
            n_fail++;
            $display("FAIL reset_pc: got pc=%h pc8=%h, want 3000/3008", bus.M_pc, bus.M_pc8);
        end
        n_tests++;
        if ({bus.M_instr, bus.M_A2, bus.M_A3, bus.M_AR, bus.M_V2, bus.M_bd, bus.M_exc,
             bus.M_valid, bus.M_hold_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_zero: instr=%h a3=%0d ar=%h valid=%b cnt=%0d, want all 0",
                     bus.M_instr, bus.M_A3, bus.M_AR, bus.M_valid, bus.M_hold_cnt);
        end
        reset = 0;
    endtask

    task automatic test_load();
        bus.E_pc = 32'h3004; bus.E_A3 = 5'd5; bus.E_AR = 32'h1234; bus.E_instr = 32'h0123_4567;
        step();
        n_tests++;
        if (bus.M_pc8 !== 32'h300C || bus.M_A3 !== 5'd5 || bus.M_AR !== 32'h1234 ||
            bus.M_valid !== 1'b1 || bus.M_instr !== 32'h0123_4567) begin
            n_fail++;
            $display("FAIL load: pc8=%h a3=%0d ar=%h valid=%b, want 300c/5/1234/1",
                     bus.M_pc8, bus.M_A3, bus.M_AR, bus.M_valid);
        end
    endtask

    task automatic test_stall_counter();
        int want;
        bus.en = 1; bus.E_pc = 32'h3020; bus.E_A3 = 5'd9; bus.E_AR = 32'hCAFE_0001;
        bus.E_V2 = 32'h55; bus.E_instr = 32'h8C00_0000;
        step();
        bus.en = 0;
        bus.E_pc = 32'h9999; bus.E_A3 = 5'd1; bus.E_AR = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            step();
            want = (i > 15) ? 15 : i;
            n_tests++;
            if (bus.M_hold_cnt !== 4'(want) || bus.M_pc !== 32'h3020 || bus.M_A3 !== 5'd9 ||
                bus.M_AR !== 32'hCAFE_0001 || bus.M_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: cnt=%0d pc=%h a3=%0d ar=%h, want cnt=%0d pc=3020 a3=9 ar=cafe0001",
                         i, bus.M_hold_cnt, bus.M_pc, bus.M_A3, bus.M_AR, want);
            end
        end
        bus.en = 1;
        step();
        n_tests++;
        if (bus.M_hold_cnt !== 4'd0 || bus.M_pc !== 32'h9999 || bus.M_A3 !== 5'd1) begin
            n_fail++;
            $display("FAIL stall_release: cnt=%0d pc=%h a3=%0d, want 0/9999/1",
                     bus.M_hold_cnt, bus.M_pc, bus.M_A3);
        end
    endtask

    task automatic test_flush_stall();
        bus.en = 0; bus.flush = 1; bus.E_pc = 32'h3010; bus.E_bd = 1; bus.E_A3 = 5'd7;
        bus.E_instr = 32'hFFFF_FFFF;
        step();
        n_tests++;
        if (bus.M_instr !== 0 || bus.M_A3 !== 0 || bus.M_valid !== 0 ||
            bus.M_pc !== 32'h3010 || bus.M_pc8 !== 32'h3018 || bus.M_bd !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: instr=%h a3=%0d valid=%b pc=%h bd=%b, want 0/0/0/3010/1",
                     bus.M_instr, bus.M_A3, bus.M_valid, bus.M_pc, bus.M_bd);
        end
        bus.flush = 0; bus.E_bd = 0;
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if (bus.M_hold_cnt !== 4'd0 || bus.M_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_hold: cnt=%0d valid=%b, want 0/0", bus.M_hold_cnt, bus.M_valid);
        end
        bus.en = 1;
    endtask

    task automatic test_exc_merge();
        bus.en = 1; bus.E_ov = 1; bus.E_exc = 0; bus.E_A3 = 5'd8;
        step();
        n_tests++;
        if (bus.M_exc !== 5'd12 || bus.M_A3 !== 5'd0 || bus.M_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_ov: exc=%0d a3=%0d valid=%b, want 12/0/1", bus.M_exc, bus.M_A3, bus.M_valid);
        end
        bus.E_exc = 5'd4;
        step();
        n_tests++;
        if (bus.M_exc !== 5'd4 || bus.M_A3 !== 5'd0) begin
            n_fail++;
            $display("FAIL exc_prior: exc=%0d a3=%0d, want 4/0", bus.M_exc, bus.M_A3);
        end
        bus.E_exc = 0; bus.E_ov = 0;
        step();
        n_tests++;
        if (bus.M_exc !== 5'd0 || bus.M_A3 !== 5'd8) begin
            n_fail++;
            $display("FAIL exc_none: exc=%0d a3=%0d, want 0/8", bus.M_exc, bus.M_A3);
        end
    endtask

    task automatic test_req_priority();
        bus.E_exc = 5'd4; bus.E_A3 = 5'd3;
        step();
        bus.req = 1; bus.flush = 1; bus.en = 0;
        step();
        n_tests++;
        if (bus.M_pc !== 32'h4180 || bus.M_pc8 !== 32'h4188 || bus.M_valid !== 1'b0 ||
            bus.M_exc !== 5'd0 || bus.M_A3 !== 5'd0) begin
            n_fail++;
            $display("FAIL req: pc=%h pc8=%h valid=%b exc=%0d, want 4180/4188/0/0",
                     bus.M_pc, bus.M_pc8, bus.M_valid, bus.M_exc);
        end
        bus.req = 0; bus.flush = 0; bus.en = 1; bus.E_exc = 0;
    endtask

    task automatic test_wrap();
        bus.E_pc = 32'hFFFF_FFFC;
        step();
        n_tests++;
        if (bus.M_pc8 !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL wrap: pc8=%h, want 00000004", bus.M_pc8);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.E_pc = 32'h3100; bus.E_A3 = 5'd2;
        step();
        bus.en = 0;
        for (int i = 0; i < 4; i++) step();
        reset = 1;
        step();
        n_tests++;
        if (bus.M_hold_cnt !== 4'd0 || bus.M_valid !== 1'b0 || bus.M_pc !== 32'h3000) begin
            n_fail++;
            $display("FAIL reset_mid_stall: cnt=%0d valid=%b pc=%h, want 0/0/3000",
                     bus.M_hold_cnt, bus.M_valid, bus.M_pc);
        end
        reset = 0; bus.en = 1;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 40) == 0);
            bus.req     = ($urandom_range(0, 20) == 0);
            bus.flush   = ($urandom_range(0, 8) == 0);
            bus.en      = ($urandom_range(0, 3) != 0);
            bus.E_instr = $urandom; bus.E_AR = $urandom; bus.E_V2 = $urandom;
            bus.E_pc    = $urandom; bus.E_A2 = 5'($urandom); bus.E_A3 = 5'($urandom);
            bus.E_bd    = 1'($urandom);
            bus.E_ov    = ($urandom_range(0, 3) == 0);
            bus.E_exc   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            step();
            n_tests++;
            if (dut_state() !== model_state()) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: got %h, want %h", i, dut_state(), model_state());
            end
        end
        drive_idle();
    endtask

    initial begin
        clear_slot(32'h3000, 1'b0);
        test_reset();
        test_load();
        test_stall_counter();
        test_flush_stall();
        test_exc_merge();
        test_req_priority();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
